// File: rtl/delta_spike_decoder.sv
// Delta-modulation spike decoder: saturating step accumulator feeding a small
// output FIFO (ready/valid), plus per-window up/down spike rate counters.
module delta_spike_decoder #(
  parameter int ACC_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int WINDOW     = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       spike,
  input  logic [3:0]       step,
  input  logic             init_load,
  input  logic [ACC_W-1:0] init_value,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] up_count,
  output logic [CNT_W-1:0] down_count,
  output logic             win_done,
  output logic             err_illegal,
  output logic             err_overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int WIN_W = $clog2(WINDOW + 1);

  logic [ACC_W-1:0] acc, acc_next;
  logic [ACC_W:0]   step_ext, sum, diff;
  logic             is_up, is_down, push, pop, full, push_ok;

  logic [ACC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] up_acc, down_acc, up_next, down_next;
  logic             win_last;

  // One extra bit of headroom lets both the carry-out and the borrow be seen before clamping.
  always_comb begin
    step_ext = {{(ACC_W-3){1'b0}}, step};
    sum      = {1'b0, acc} + step_ext;
    diff     = {1'b0, acc} - step_ext;
    is_up    = in_valid && (spike == 2'b01);
    is_down  = in_valid && (spike == 2'b10);
    acc_next = acc;
    push     = 1'b0;
    if (init_load) begin
      acc_next = init_value;
    end else if (is_up) begin
      acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      push     = 1'b1;
    end else if (is_down) begin
      acc_next = diff[ACC_W] ? '0 : diff[ACC_W-1:0];
      push     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else       acc <= acc_next;
  end

  assign out_valid = (occ != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;
  assign full      = (occ == OCC_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign push_ok   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= acc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (in_valid && (spike == 2'b11)) err_illegal  <= 1'b1;
      if (push && !push_ok)             err_overflow <= 1'b1;
    end
  end

  // Window counters see the raw spike field, independent of init_load.
  always_comb begin
    up_next   = (in_valid && spike == 2'b01 && up_acc   != '1) ? up_acc   + CNT_W'(1) : up_acc;
    down_next = (in_valid && spike == 2'b10 && down_acc != '1) ? down_acc + CNT_W'(1) : down_acc;
    win_last  = in_valid && (win_cnt == WIN_W'(WINDOW - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt    <= '0;
      up_acc     <= '0;
      down_acc   <= '0;
      up_count   <= '0;
      down_count <= '0;
      win_done   <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (win_last) begin
        up_count   <= up_next;
        down_count <= down_next;
        win_done   <= 1'b1;
        win_cnt    <= '0;
        up_acc     <= '0;
        down_acc   <= '0;
      end else if (in_valid) begin
        win_cnt  <= win_cnt + WIN_W'(1);
        up_acc   <= up_next;
        down_acc <= down_next;
      end
    end
  end

endmodule

// File: doc/delta_spike_decoder.md
Name: delta_spike_decoder

Overview:
Downstream consumer of the delta-modulation spike encoder. Takes the 2-bit up/down spike stream and reconstructs the signal with a saturating step accumulator. Each reconstructed sample is queued in a small FIFO and presented on a ready/valid output. Per-window up/down spike counts are also kept for rate monitoring.

Parameters:
ACC_W, 8, accumulator/output sample width (>= 4)
FIFO_DEPTH, 4, output queue depth (power of 2, >= 2)
WINDOW, 16, in_valid cycles per rate-count window (>= 2)
CNT_W, 5, width of up/down window counters (saturating)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  spike field valid this cycle
spike  input  2  bit0 = up spike, bit1 = down spike (encoder output)
step  input  4  reconstruction step; same threshold the encoder uses
init_load  input  1  load accumulator with init_value
init_value  input  ACC_W  accumulator preload value
out_ready  input  1  downstream accepts out_data
out_valid  output  1  FIFO non-empty
out_data  output  ACC_W  FIFO head sample
up_count  output  CNT_W  up spikes in last completed window
down_count  output  CNT_W  down spikes in last completed window
win_done  output  1  one-cycle pulse when window counts update
err_illegal  output  1  sticky: spike==2'b11 seen with in_valid
err_overflow  output  1  sticky: sample dropped, FIFO full

Behaviour:
- Reset (sync, clk rising edge, reset=1):
  - acc=0; FIFO empty; out_valid=0; out_data=0.
  - up_count, down_count and internal counters=0; win_done=0.
  - err_illegal=0; err_overflow=0.
- Reset overrides every other input in the same cycle.
- Reset mid-operation discards queued samples without emitting them.
- Accumulator update, priority order:
  - init_load=1: acc <= init_value. Any spike that cycle is ignored for acc and FIFO but still counted for the window if in_valid=1. No FIFO push.
  - in_valid=1, spike=2'b01: acc <= min(acc+step, 2^ACC_W-1).
  - in_valid=1, spike=2'b10: acc <= max(acc-step, 0).
  - in_valid=1, spike=2'b00: acc unchanged; no push.
  - in_valid=1, spike=2'b11: acc unchanged; no push; err_illegal <= 1.
  - step is zero-extended to ACC_W. Arithmetic uses ACC_W+1 bits, then clamps.
- FIFO push:
  - Every accepted up/down spike pushes the updated acc value (the post-clamp value that becomes acc).
  - Saturated steps still push.
- Latency: spike at edge N -> out_valid=1 and out_data=new value after edge N+1, if the FIFO was empty.
- Output handshake:
  - Pop when out_valid && out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_ready with empty FIFO: no effect.
- Full FIFO:
  - Push with no pop in the same cycle: sample dropped; err_overflow <= 1; acc still updates.
  - Push and pop in the same cycle when full: both succeed, occupancy stays FIFO_DEPTH.
  - Push and pop when empty: the sample is not bypassed; it appears the next cycle.
- Sticky errors clear only on reset.
- Window counting:
  - win_cnt increments on each in_valid.
  - up_acc/down_acc increment on spike bit0/bit1 with in_valid; 2'b11 increments neither. Both saturate at 2^CNT_W-1.
  - On the in_valid that brings win_cnt to WINDOW: up_count/down_count <= final values including this cycle's spike; win_done=1 for one cycle; internal counters restart at 0.
  - Cycles without in_valid do not advance the window.

Test Plan:
- Reset, then step=3, spikes 01,01,10 on consecutive cycles, out_ready=1 -> out_data sequence 3,6,3; out_valid high one cycle per sample; no errors.
- ACC_W=8, init_load with init_value=250, then step=15 spike 01 -> acc=255 pushed. Init_value=5, step=15 spike 10 -> 0 pushed.
- out_ready=0, five 01 spikes with step=1 from 0 -> FIFO holds 1..4; 5th dropped; err_overflow=1; acc=5. Then out_ready=1 -> drains 1,2,3,4; out_valid falls.
- FIFO full with out_ready=1 and a spike in the same cycle -> pop and push both succeed; err_overflow stays 0.
- in_valid with spike=2'b11 -> no push, acc unchanged, err_illegal=1, window counters unchanged but window advances.
- WINDOW=16: 10 up, 4 down, 2 zero spikes -> win_done pulse on the 16th; up_count=10, down_count=4. Assert reset mid-window -> all outputs 0 next cycle.
